// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: port indices, op encoding, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_ram_arbiter_pkg;

   // Default geometry of the 256x16 data RAM
   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 16;

   // Requester indices, also used as the read-return owner tag
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // Meaning of a requester's we bit
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // Read in flight: valid plus the port that owns the returning data
   typedef struct packed {
      logic vld;
      logic owner;
   } rd_tag_t;

   // Two requests collide only when both are present and of the same type,
   // since the RAM has one write port and one read port.
   function automatic logic same_type_conflict(input logic a_req, input logic a_we,
                                               input logic b_req, input logic b_we);
      return a_req & b_req & (a_we == b_we);
   endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between CPU/debug masters, the arbiter and the data RAM.
// Latency: n/a (wires only).
// Backpressure: req is held until gnt; the slave modport is the arbiter's view.
//   cpu/dbg: req, we, addr, wdata in; gnt, rvalid, rdata out
//   ram:     write/addr_write/data_write, read/addr_read out; data_read in
//   stats:   o_conflict_cnt out
interface data_ram_arbiter_if
   import data_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) ();

   logic              i_cpu_req;
   logic              i_cpu_we;
   logic [ADDR_W-1:0] i_cpu_addr;
   logic [DATA_W-1:0] i_cpu_wdata;
   logic              o_cpu_gnt;
   logic              o_cpu_rvalid;
   logic [DATA_W-1:0] o_cpu_rdata;

   logic              i_dbg_req;
   logic              i_dbg_we;
   logic [ADDR_W-1:0] i_dbg_addr;
   logic [DATA_W-1:0] i_dbg_wdata;
   logic              o_dbg_gnt;
   logic              o_dbg_rvalid;
   logic [DATA_W-1:0] o_dbg_rdata;

   logic              o_ram_write;
   logic [ADDR_W-1:0] o_ram_addr_write;
   logic [DATA_W-1:0] o_ram_data_write;
   logic              o_ram_read;
   logic [ADDR_W-1:0] o_ram_addr_read;
   logic [DATA_W-1:0] i_ram_data_read;

   logic [7:0]        o_conflict_cnt;

   modport slave (
      input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
      output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
      input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
      output o_ram_write, o_ram_addr_write, o_ram_data_write,
      output o_ram_read, o_ram_addr_read,
      input  i_ram_data_read,
      output o_conflict_cnt
   );

   modport master (
      output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
      input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
      output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
      input  o_ram_write, o_ram_addr_write, o_ram_data_write,
      input  o_ram_read, o_ram_addr_read,
      output i_ram_data_read,
      input  o_conflict_cnt
   );

endinterface

// File: rtl/data_ram_arbiter_pick.sv
// Winner select for same-type CPU/debug collisions, CPU first with a debug starvation escape.
// Latency: grants are combinational from the current requests and starve_cnt.
// Backpressure: the losing port sees gnt=0 and must hold its request.
//   in:  i_clk, i_rst_n, cpu_req/cpu_we, dbg_req/dbg_we
//   out: cpu_gnt, dbg_gnt, conflict
module ram_conflict_pick
   import data_ram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic cpu_req,
   input  logic cpu_we,
   input  logic dbg_req,
   input  logic dbg_we,
   output logic cpu_gnt,
   output logic dbg_gnt,
   output logic conflict
);

   // +2 keeps the counter at least one bit wide even for STARVE_LIMIT=0
   localparam int                CNT_W = $clog2(STARVE_LIMIT + 2);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             dbg_turn;

   assign conflict = same_type_conflict(cpu_req, cpu_we, dbg_req, dbg_we);
   assign dbg_turn = (starve_cnt == LIMIT);

   // Without a conflict every requester is granted; with one, exactly one side loses
   assign cpu_gnt = cpu_req & ~(conflict & dbg_turn);
   assign dbg_gnt = dbg_req & ~(conflict & ~dbg_turn);

   // Counts conflicts lost by the debug port. It cannot pass LIMIT: at LIMIT the
   // debug port wins the next conflict and the counter clears.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
      end else if (dbg_gnt) begin
         starve_cnt <= '0;
      end else if (conflict && !dbg_turn) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the 256x16 data RAM (one write + one registered read port) between CPU and debug.
// Latency: grant combinational; read data returns one cycle after the read grant.
// Backpressure: same-type collisions stall the loser (gnt=0) until it wins.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : cpu/dbg request+return, RAM drive, conflict counter (slave view)
module data_ram_arbiter
   import data_ram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = MEM_ADDR_W,
   parameter int DATA_W       = MEM_DATA_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   data_ram_arbiter_if.slave    bus
);

   logic cpu_gnt, dbg_gnt, conflict;
   logic cpu_wr_g, cpu_rd_g, dbg_wr_g, dbg_rd_g;

   logic              ram_write;
   logic [ADDR_W-1:0] ram_addr_write;
   logic [DATA_W-1:0] ram_data_write;
   logic              ram_read;
   logic [ADDR_W-1:0] ram_addr_read;

   rd_tag_t    rd_tag;
   logic [7:0] conflict_cnt;
   logic       cpu_rvalid, dbg_rvalid;

   ram_conflict_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .cpu_req  (bus.i_cpu_req),
      .cpu_we   (bus.i_cpu_we),
      .dbg_req  (bus.i_dbg_req),
      .dbg_we   (bus.i_dbg_we),
      .cpu_gnt  (cpu_gnt),
      .dbg_gnt  (dbg_gnt),
      .conflict (conflict)
   );

   assign cpu_wr_g = cpu_gnt & (bus.i_cpu_we == OP_WRITE);
   assign cpu_rd_g = cpu_gnt & (bus.i_cpu_we == OP_READ);
   assign dbg_wr_g = dbg_gnt & (bus.i_dbg_we == OP_WRITE);
   assign dbg_rd_g = dbg_gnt & (bus.i_dbg_we == OP_READ);

   // At most one write and one read are granted per cycle, so each RAM port
   // has a single source; unused ports are driven to zero.
   always_comb begin
      ram_write      = 1'b0;
      ram_addr_write = '0;
      ram_data_write = '0;
      if (cpu_wr_g) begin
         ram_write      = 1'b1;
         ram_addr_write = bus.i_cpu_addr;
         ram_data_write = bus.i_cpu_wdata;
      end else if (dbg_wr_g) begin
         ram_write      = 1'b1;
         ram_addr_write = bus.i_dbg_addr;
         ram_data_write = bus.i_dbg_wdata;
      end
   end

   always_comb begin
      ram_read      = 1'b0;
      ram_addr_read = '0;
      if (cpu_rd_g) begin
         ram_read      = 1'b1;
         ram_addr_read = bus.i_cpu_addr;
      end else if (dbg_rd_g) begin
         ram_read      = 1'b1;
         ram_addr_read = bus.i_dbg_addr;
      end
   end

   // Owner tag travels alongside the RAM's registered read; reset drops it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_tag       <= '0;
         conflict_cnt <= '0;
      end else begin
         rd_tag.vld   <= ram_read;
         rd_tag.owner <= dbg_rd_g ? PORT_DBG : PORT_CPU;
         if (conflict && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
         end
      end
   end

   assign cpu_rvalid = rd_tag.vld & (rd_tag.owner == PORT_CPU);
   assign dbg_rvalid = rd_tag.vld & (rd_tag.owner == PORT_DBG);

   assign bus.o_cpu_gnt        = cpu_gnt;
   assign bus.o_dbg_gnt        = dbg_gnt;
   assign bus.o_cpu_rvalid     = cpu_rvalid;
   assign bus.o_dbg_rvalid     = dbg_rvalid;
   // The RAM holds its last read value; only the owner sees it, and only while valid
   assign bus.o_cpu_rdata      = cpu_rvalid ? bus.i_ram_data_read : '0;
   assign bus.o_dbg_rdata      = dbg_rvalid ? bus.i_ram_data_read : '0;
   assign bus.o_ram_write      = ram_write;
   assign bus.o_ram_addr_write = ram_addr_write;
   assign bus.o_ram_data_write = ram_data_write;
   assign bus.o_ram_read       = ram_read;
   assign bus.o_ram_addr_read  = ram_addr_read;
   assign bus.o_conflict_cnt   = conflict_cnt;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural 256x16 RAM attached.
// Latency: inputs change 1 time unit after posedge, outputs are checked at negedge.
// Backpressure: stimulus holds or drops requests as each scenario dictates.
module tb_data_ram_arbiter;

   logic i_clk;
   logic i_rst_n;
   int   checks = 0;
   int   errors = 0;

   data_ram_arbiter_if bus ();

   data_ram_arbiter dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // RAM model: independent write port, registered read port, old data on read-during-write
   logic [15:0] mem [256];
   always @(posedge i_clk) begin
      if (bus.o_ram_write) mem[bus.o_ram_addr_write] <= bus.o_ram_data_write;
   end
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)             bus.i_ram_data_read <= 16'h0000;
      else if (bus.o_ram_read)  bus.i_ram_data_read <= mem[bus.o_ram_addr_read];
   end

   task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw, input logic [7:0] da, input logic [15:0] dd);
      bus.i_cpu_req = cr; bus.i_cpu_we = cw; bus.i_cpu_addr = ca; bus.i_cpu_wdata = cd;
      bus.i_dbg_req = dr; bus.i_dbg_we = dw; bus.i_dbg_addr = da; bus.i_dbg_wdata = dd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      idle();
      repeat (2) settle();
      checks++; if (bus.o_cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid got %h expected 0", bus.o_cpu_rvalid); end
      checks++; if (bus.o_dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dbg_rvalid got %h expected 0", bus.o_dbg_rvalid); end
      checks++; if (bus.o_conflict_cnt !== 8'd0) begin errors++; $display("FAIL reset_conflict_cnt got %h expected 00", bus.o_conflict_cnt); end
      checks++; if ({bus.o_ram_write, bus.o_ram_read} !== 2'b00) begin errors++; $display("FAIL reset_ram_ctrl got %b expected 00", {bus.o_ram_write, bus.o_ram_read}); end
      i_rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      tick(); drive(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000); settle();
      checks++; if (bus.o_cpu_gnt !== 1'b1) begin errors++; $display("FAIL wr_cpu_gnt got %h expected 1", bus.o_cpu_gnt); end
      checks++; if ({bus.o_ram_write, bus.o_ram_addr_write, bus.o_ram_data_write} !== {1'b1, 8'h10, 16'hBEEF})
         begin errors++; $display("FAIL wr_ram_port got %h expected 110beef", {bus.o_ram_write, bus.o_ram_addr_write, bus.o_ram_data_write}); end
      tick(); drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000); settle();
      checks++; if ({bus.o_cpu_gnt, bus.o_ram_read, bus.o_ram_addr_read} !== {2'b11, 8'h10})
         begin errors++; $display("FAIL rd_grant got %h expected 310", {bus.o_cpu_gnt, bus.o_ram_read, bus.o_ram_addr_read}); end
      tick(); idle(); settle();
      checks++; if ({bus.o_cpu_rvalid, bus.o_cpu_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL rd_cpu_return got %h expected 1beef", {bus.o_cpu_rvalid, bus.o_cpu_rdata}); end
      checks++; if ({bus.o_dbg_rvalid, bus.o_dbg_rdata} !== 17'd0) begin errors++; $display("FAIL rd_dbg_quiet got %h expected 0", {bus.o_dbg_rvalid, bus.o_dbg_rdata}); end
      tick(); settle();
      checks++; if ({bus.o_cpu_rvalid, bus.o_cpu_rdata, bus.o_ram_read} !== 18'd0) begin errors++; $display("FAIL idle_gated got %h expected 0", {bus.o_cpu_rvalid, bus.o_cpu_rdata, bus.o_ram_read}); end
   endtask

   task automatic test_read_during_write();
      tick(); drive(1'b1, 1'b1, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick(); drive(1'b1, 1'b1, 8'h20, 16'h1234, 1'b1, 1'b0, 8'h20, 16'h0000); settle();
      checks++; if ({bus.o_cpu_gnt, bus.o_dbg_gnt} !== 2'b11) begin errors++; $display("FAIL rdw_grants got %b expected 11", {bus.o_cpu_gnt, bus.o_dbg_gnt}); end
      tick(); drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000); settle();
      checks++; if ({bus.o_dbg_rvalid, bus.o_dbg_rdata, bus.o_cpu_rvalid} !== {1'b1, 16'h0000, 1'b0})
         begin errors++; $display("FAIL rdw_old_data got %h expected 20000", {bus.o_dbg_rvalid, bus.o_dbg_rdata, bus.o_cpu_rvalid}); end
      tick(); idle(); settle();
      checks++; if ({bus.o_dbg_rvalid, bus.o_dbg_rdata} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL rdw_new_data got %h expected 11234", {bus.o_dbg_rvalid, bus.o_dbg_rdata}); end
   endtask

   task automatic test_starvation();
      logic [5:0] exp_cpu;
      exp_cpu = 6'b101111;  // bit i: CPU wins conflict cycle i; debug wins cycle 4
      for (int i = 0; i < 6; i++) begin
         tick(); drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000); settle();
         checks++; if ({bus.o_cpu_gnt, bus.o_dbg_gnt} !== {exp_cpu[i], ~exp_cpu[i]})
            begin errors++; $display("FAIL starve_gnt cycle %0d got %b expected %b", i, {bus.o_cpu_gnt, bus.o_dbg_gnt}, {exp_cpu[i], ~exp_cpu[i]}); end
         if (i == 5) begin
            checks++; if ({bus.o_dbg_rvalid, bus.o_dbg_rdata} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL starve_dbg_return got %h expected 11234", {bus.o_dbg_rvalid, bus.o_dbg_rdata}); end
         end
      end
      tick(); idle(); settle();
      checks++; if (bus.o_conflict_cnt !== 8'd6) begin errors++; $display("FAIL starve_conflict_cnt got %0d expected 6", bus.o_conflict_cnt); end
      checks++; if ({bus.o_cpu_rvalid, bus.o_cpu_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL starve_cpu_return got %h expected 1beef", {bus.o_cpu_rvalid, bus.o_cpu_rdata}); end
   endtask

   task automatic test_write_conflict();
      tick(); drive(1'b1, 1'b1, 8'h30, 16'hAAAA, 1'b1, 1'b1, 8'h30, 16'h5555); settle();
      checks++; if ({bus.o_cpu_gnt, bus.o_dbg_gnt, bus.o_ram_data_write} !== {2'b10, 16'hAAAA})
         begin errors++; $display("FAIL wconf_first got %h expected 2aaaa", {bus.o_cpu_gnt, bus.o_dbg_gnt, bus.o_ram_data_write}); end
      tick(); drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h30, 16'h5555); settle();
      checks++; if ({bus.o_dbg_gnt, bus.o_ram_addr_write, bus.o_ram_data_write} !== {1'b1, 8'h30, 16'h5555})
         begin errors++; $display("FAIL wconf_second got %h expected 1305555", {bus.o_dbg_gnt, bus.o_ram_addr_write, bus.o_ram_data_write}); end
      tick(); drive(1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      tick(); idle(); settle();
      checks++; if ({bus.o_cpu_rvalid, bus.o_cpu_rdata} !== {1'b1, 16'h5555}) begin errors++; $display("FAIL wconf_readback got %h expected 15555", {bus.o_cpu_rvalid, bus.o_cpu_rdata}); end
      checks++; if (bus.o_conflict_cnt !== 8'd7) begin errors++; $display("FAIL wconf_conflict_cnt got %0d expected 7", bus.o_conflict_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  addrs [3];
      logic [15:0] datas [3];
      logic        dbg_port [3];
      addrs = '{8'h10, 8'h20, 8'h30};
      datas = '{16'hBEEF, 16'h1234, 16'h5555};
      dbg_port = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i < 3) drive(~dbg_port[i], 1'b0, addrs[i], 16'h0000, dbg_port[i], 1'b0, addrs[i], 16'h0000);
         else       idle();
         settle();
         if (i < 3) begin
            checks++; if ({bus.o_ram_read, bus.o_ram_addr_read} !== {1'b1, addrs[i]}) begin errors++; $display("FAIL b2b_issue %0d got %h expected %h", i, {bus.o_ram_read, bus.o_ram_addr_read}, {1'b1, addrs[i]}); end
         end
         if (i > 0) begin
            checks++;
            if (dbg_port[i-1] ? ({bus.o_dbg_rvalid, bus.o_dbg_rdata, bus.o_cpu_rvalid} !== {1'b1, datas[i-1], 1'b0})
                              : ({bus.o_cpu_rvalid, bus.o_cpu_rdata, bus.o_dbg_rvalid} !== {1'b1, datas[i-1], 1'b0}))
               begin errors++; $display("FAIL b2b_return %0d got cpu %b/%h dbg %b/%h expected data %h", i, bus.o_cpu_rvalid, bus.o_cpu_rdata, bus.o_dbg_rvalid, bus.o_dbg_rdata, datas[i-1]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(); drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000); settle();
      checks++; if (bus.o_cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %h expected 1", bus.o_cpu_gnt); end
      #2; i_rst_n = 1'b0; idle(); #1;
      checks++; if ({bus.o_cpu_rvalid, bus.o_dbg_rvalid, bus.o_cpu_rdata, bus.o_conflict_cnt, bus.o_ram_read, bus.o_ram_write} !== 28'd0)
         begin errors++; $display("FAIL rstmid_outputs got %h expected 0", {bus.o_cpu_rvalid, bus.o_dbg_rvalid, bus.o_cpu_rdata, bus.o_conflict_cnt, bus.o_ram_read, bus.o_ram_write}); end
      repeat (2) @(posedge i_clk);
      @(negedge i_clk); i_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); settle();
         checks++; if ({bus.o_cpu_rvalid, bus.o_dbg_rvalid} !== 2'b00) begin errors++; $display("FAIL rstmid_no_rvalid %0d got %b expected 00", i, {bus.o_cpu_rvalid, bus.o_dbg_rvalid}); end
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         tick(); drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000); settle();
         if (i == 254) begin
            checks++; if (bus.o_conflict_cnt !== 8'd254) begin errors++; $display("FAIL sat_cnt_254 got %0d expected 254", bus.o_conflict_cnt); end
         end
      end
      tick(); idle(); settle();
      checks++; if (bus.o_conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_255 got %0d expected 255", bus.o_conflict_cnt); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_read_during_write();
      test_starvation();
      test_write_conflict();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
